alsu_arbiter: RTL and testbench
===============================

Name: alsu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one ALSU instance between NUM_REQ requesters.
- Accepts a packed command per requester through a valid/ready handshake, drives the ALSU input pins, and waits the ALSU pipeline latency.
- Captures out/leds into a registered response returned to the winning requester, tagged with its ID.
- Sits between requester blocks and the ALSU, in place of a testbench driver.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..8); ID_W = $clog2(NUM_REQ) (localparam).
- ALSU_LAT, 2, clocks from a command-register update until alsu_out/alsu_leds reflect that command.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester command valid.
- req_ready  output  NUM_REQ  one-hot grant/accept, combinational.
- req_cmd  input  16*NUM_REQ  slice i = {opcode[15:13], A[12:10], B[9:7], cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}.
- alsu_opcode  output  3  to ALSU.
- alsu_A, alsu_B  output  3  to ALSU, signed.
- alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B  output  1 each  to ALSU.
- alsu_out  input  6  ALSU result.
- alsu_leds  input  16  ALSU error LEDs.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_out  output  6  captured alsu_out.
- rsp_err  output  1  captured |alsu_leds.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset low, async) forces:
  - state IDLE, rr_ptr 0;
  - command register all zeros, so every alsu_* output = 0;
  - rsp_valid 0, rsp_id 0, rsp_out 0, rsp_err 0, busy 0, req_ready 0.
- Reset mid-operation discards any in-flight command and any pending response. No response is ever produced for it.
- FSM states: IDLE, WAIT, CAPT, RESP.
- IDLE:
  - If any req_valid is set, grant g = first set bit searching upward from rr_ptr, with wrap-around.
  - req_ready[g] = 1 in the same cycle; all other ready bits are 0.
  - On that edge: command register <= req_cmd slice g, rsp_id <= g, rr_ptr <= (g+1) mod NUM_REQ, cnt <= ALSU_LAT-1, state -> WAIT.
  - If no req_valid is set, stay in IDLE and hold the command register.
- WAIT:
  - Command register held stable.
  - cnt decrements each clock; at cnt==0, state -> CAPT.
  - WAIT lasts exactly ALSU_LAT cycles.
- CAPT (1 cycle): rsp_out <= alsu_out, rsp_err <= |alsu_leds, rsp_valid <= 1, state -> RESP.
  - Capture is mandatory: shift/rotate opcodes keep changing alsu_out every clock while inputs are held.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0; no new grant is issued.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, state -> IDLE.
  - The earliest next grant is the following cycle.
- Latency and throughput:
  - Command accepted in cycle t gives rsp_valid in cycle t+ALSU_LAT+2 (t+4 at default).
  - Peak throughput is one op per ALSU_LAT+3 cycles when rsp_ready is tied high.
- req_ready is 0 in every state except IDLE. A requester whose req_valid is dropped before grant loses nothing; the arbiter does not latch requests.
- rsp_out and rsp_err keep their last values after the handshake; only rsp_valid deasserts.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0…; no requester waits more than NUM_REQ-1 grants.
- The command register is driven directly from flops, so alsu_* outputs are glitch-free.

Test Plan:
- Single op: after reset, req 0 sends opcode=3'b011, A=2, B=3, all flags 0 -> req_ready[0]=1 in cycle 0; rsp_valid in cycle 4 with rsp_id=0, rsp_out=6'd6, rsp_err=0.
- Round-robin: req_valid=2'b11 held, rsp_ready=1 -> grant order 0,1,0,1; req 1 issues opcode=3'b010, A=1, B=1, cin=0 -> rsp_out=6'd2 tagged rsp_id=1.
- Backpressure: rsp_ready=0 for 10 cycles during RESP with req 1 valid -> rsp_* stable, req_ready stays 0; rsp_ready=1 -> next cycle IDLE grants req 1.
- Invalid opcode: opcode=3'b110 -> rsp_out=0, rsp_err=1; the next valid op returns rsp_err=0.
- Shift capture: opcode=3'b100, direction=1, serial_in=1, inputs held -> rsp_out equals the ALSU model value at the CAPT cycle and does not change afterwards.
- Async reset asserted during WAIT -> rsp_valid, busy and alsu_* are 0 immediately; after reset release, no response is produced and the first grant goes to req 0.

Source files
------------

// File: rtl/alsu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALSU between NUM_REQ requesters.
// Grants a command, waits out the ALSU pipeline, captures the result and returns it tagged with the owner ID.
module alsu_arbiter #(
    parameter int  NUM_REQ  = 2,
    parameter int  ALSU_LAT = 2,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_cmd,
    output logic [2:0]              alsu_opcode,
    output logic signed [2:0]       alsu_A,
    output logic signed [2:0]       alsu_B,
    output logic                    alsu_cin,
    output logic                    alsu_serial_in,
    output logic                    alsu_direction,
    output logic                    alsu_red_op_A,
    output logic                    alsu_red_op_B,
    output logic                    alsu_bypass_A,
    output logic                    alsu_bypass_B,
    input  logic [5:0]              alsu_out,
    input  logic [15:0]             alsu_leds,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [5:0]              rsp_out,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int CNT_W = (ALSU_LAT > 1) ? $clog2(ALSU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, CAPT, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       cmd_q;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     cand;
    logic [ID_W-1:0]   next_ptr;

    // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign next_ptr = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (reset && state == IDLE && grant_found)
            req_ready = NUM_REQ'(1) << grant_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            cmd_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out   <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_found) begin
                        cmd_q  <= req_cmd[16*int'(grant_idx) +: 16];
                        rsp_id <= grant_idx;
                        rr_ptr <= next_ptr;
                        cnt    <= CNT_W'(ALSU_LAT-1);
                        busy   <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0)
                        state <= CAPT;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                // Shift/rotate results keep moving while inputs are held, so sample exactly once here.
                CAPT: begin
                    rsp_out   <= alsu_out;
                    rsp_err   <= |alsu_leds;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign alsu_opcode    = cmd_q[15:13];
    assign alsu_A         = cmd_q[12:10];
    assign alsu_B         = cmd_q[9:7];
    assign alsu_cin       = cmd_q[6];
    assign alsu_serial_in = cmd_q[5];
    assign alsu_direction = cmd_q[4];
    assign alsu_red_op_A  = cmd_q[3];
    assign alsu_red_op_B  = cmd_q[2];
    assign alsu_bypass_A  = cmd_q[1];
    assign alsu_bypass_B  = cmd_q[0];

endmodule

// File: tb/tb_alsu_arbiter.sv
// Bench for alsu_arbiter: a two-stage ALSU stub, a transaction-level reference model checked every cycle,
// and directed scenarios with hand-computed literal expectations.
module tb_alsu_arbiter;

    localparam int N   = 3;
    localparam int IDW = $clog2(N);

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [16*N-1:0]    req_cmd;
    logic [2:0]         alsu_opcode;
    logic signed [2:0]  alsu_A, alsu_B;
    logic               alsu_cin, alsu_serial_in, alsu_direction;
    logic               alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic [5:0]         alsu_out;
    logic [15:0]        alsu_leds;
    logic               rsp_valid, rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [5:0]         rsp_out;
    logic               rsp_err, busy;
    logic [15:0]        alsu_bus;

    int n_checks = 0;
    int n_errors = 0;

    alsu_arbiter #(.NUM_REQ(N), .ALSU_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    assign alsu_bus = {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_direction,
                       alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B};

    function automatic logic [15:0] mkCmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                          input logic cin, input logic sin, input logic dir,
                                          input logic ra, input logic rb, input logic ba, input logic bb);
        return {op, a, b, cin, sin, dir, ra, rb, ba, bb};
    endfunction

    function automatic logic alsuInvalid(input logic [15:0] c);
        return (c[15:14] == 2'b11) || ((c[3] | c[2]) && c[15:14] != 2'b00);
    endfunction

    function automatic logic [5:0] alsuNext(input logic [15:0] c, input logic [5:0] prev);
        logic signed [2:0] a, b, x;
        logic [5:0] r;
        a = c[12:10];
        b = c[9:7];
        r = 6'd0;
        if (c[1])
            r = 6'(a);
        else if (c[0])
            r = 6'(b);
        else begin
            case (c[15:13])
                3'd0: begin x = a & b; r = c[3] ? {5'b0, &a} : c[2] ? {5'b0, &b} : {{3{x[2]}}, x}; end
                3'd1: begin x = a ^ b; r = c[3] ? {5'b0, ^a} : c[2] ? {5'b0, ^b} : {{3{x[2]}}, x}; end
                3'd2: r = 6'(a) + 6'(b) + 6'(c[6]);
                3'd3: r = 6'(a) * 6'(b);
                3'd4: r = c[4] ? {prev[4:0], c[5]} : {c[5], prev[5:1]};
                3'd5: r = c[4] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
                default: r = 6'd0;
            endcase
        end
        return r;
    endfunction

    // ALSU stand-in: inputs registered, then result registered, giving two clocks of latency.
    logic [15:0] stub_s1;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            stub_s1   <= '0;
            alsu_out  <= '0;
            alsu_leds <= '0;
        end else begin
            stub_s1 <= alsu_bus;
            if (alsuInvalid(stub_s1)) begin
                alsu_out  <= 6'd0;
                alsu_leds <= 16'hFFFF;
            end else begin
                alsu_out  <= alsuNext(stub_s1, alsu_out);
                alsu_leds <= 16'h0000;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_checks++;
        n_errors++;
        $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    logic [16*N-1:0] cmds;

    task automatic applyStimulus(input logic [N-1:0] v, input logic [16*N-1:0] c, input logic rr);
        @(posedge clk);
        #1;
        req_valid = v;
        req_cmd   = c;
        rsp_ready = rr;
    endtask

    task automatic waitGrant(output int idx);
        idx = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int j = 0; j < N; j++)
                    if (req_ready[j]) idx = j;
                return;
            end
        end
        timeoutFail("grant_wait");
    endtask

    task automatic waitRsp();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid) return;
        end
        timeoutFail("rsp_wait");
    endtask

    // Transaction-level reference: a grant in cycle t owns the ALSU until its response handshake,
    // and the response appears ALSU_LAT+2 cycles after the grant.
    int             cyc = 0;
    bit             m_busy;
    int             m_grant_cyc;
    int             m_ptr;
    logic [15:0]    m_cmd;
    logic [IDW-1:0] m_id;
    logic [5:0]     m_out;
    logic           m_err;
    logic [N-1:0]   exp_ready;
    logic           exp_valid;
    int             g, cidx;

    always @(negedge clk) begin
        if (!reset) begin
            m_busy = 1'b0; m_ptr = 0; m_cmd = '0; m_id = '0; m_out = '0; m_err = 1'b0;
            checkOutput("rst_req_ready", req_ready, 0);
            checkOutput("rst_rsp_valid", rsp_valid, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_alsu_bus", alsu_bus, 0);
        end else begin
            cyc++;
            exp_ready = '0;
            g = -1;
            if (!m_busy)
                for (int k = 0; k < N; k++) begin
                    cidx = (m_ptr + k) % N;
                    if (g < 0 && req_valid[cidx]) g = cidx;
                end
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_valid = m_busy && (cyc - m_grant_cyc >= 4);
            checkOutput("m_req_ready", req_ready, exp_ready);
            checkOutput("m_busy", busy, m_busy);
            checkOutput("m_rsp_valid", rsp_valid, exp_valid);
            checkOutput("m_rsp_id", rsp_id, m_id);
            checkOutput("m_rsp_out", rsp_out, m_out);
            checkOutput("m_rsp_err", rsp_err, m_err);
            checkOutput("m_alsu_bus", alsu_bus, m_cmd);
            if (m_busy && cyc - m_grant_cyc == 3) begin
                if (alsuInvalid(m_cmd)) begin
                    m_out = 6'd0; m_err = 1'b1;
                end else if (!m_cmd[1] && !m_cmd[0] && m_cmd[15:14] == 2'b10) begin
                    m_out = alsu_out; m_err = 1'b0;
                end else begin
                    m_out = alsuNext(m_cmd, 6'd0); m_err = 1'b0;
                end
            end
            if (exp_valid && rsp_ready)
                m_busy = 1'b0;
            else if (g >= 0) begin
                m_busy      = 1'b1;
                m_grant_cyc = cyc;
                m_cmd       = req_cmd[16*g +: 16];
                m_id        = IDW'(g);
                m_ptr       = (g + 1) % N;
            end
        end
    end

    function automatic logic [15:0] randCmd();
        return mkCmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    endfunction

    int idx;

    initial begin
        reset = 1'b0; req_valid = '0; req_cmd = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rsp_id", rsp_id, 0);
        checkOutput("reset_rsp_out", rsp_out, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        @(posedge clk); #1 reset = 1'b1;

        $display("[TB] single op");
        cmds = '0;
        cmds[15:0]  = mkCmd(3'b011, 3'd2, 3'd3, 0, 0, 0, 0, 0, 0, 0);
        cmds[31:16] = mkCmd(3'b010, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(3'b001, cmds, 1'b1);
        @(negedge clk);
        checkOutput("single_ready", req_ready, 3'b001);
        applyStimulus(3'b000, cmds, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput("single_rsp_valid", rsp_valid, k == 4);
        end
        checkOutput("single_rsp_id", rsp_id, 0);
        checkOutput("single_rsp_out", rsp_out, 6'd6);
        checkOutput("single_rsp_err", rsp_err, 0);

        $display("[TB] round robin");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        applyStimulus(3'b011, cmds, 1'b1);
        for (int k = 0; k < 4; k++) begin
            waitGrant(idx);
            checkOutput("rr_grant", idx, k % 2);
            waitRsp();
            checkOutput("rr_rsp_id", rsp_id, k % 2);
            checkOutput("rr_rsp_out", rsp_out, (k % 2) ? 6'd2 : 6'd6);
        end

        $display("[TB] backpressure");
        applyStimulus(3'b001, cmds, 1'b0);
        waitGrant(idx);
        checkOutput("bp_first_grant", idx, 0);
        applyStimulus(3'b010, cmds, 1'b0);
        waitRsp();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", rsp_valid, 1);
            checkOutput("bp_rsp_id", rsp_id, 0);
            checkOutput("bp_rsp_out", rsp_out, 6'd6);
            checkOutput("bp_req_ready", req_ready, 0);
        end
        applyStimulus(3'b010, cmds, 1'b1);
        @(negedge clk);
        checkOutput("bp_handshake_ready", req_ready, 0);
        @(negedge clk);
        checkOutput("bp_next_grant", req_ready, 3'b010);
        applyStimulus(3'b000, cmds, 1'b1);
        waitRsp();
        checkOutput("bp_req1_id", rsp_id, 1);
        checkOutput("bp_req1_out", rsp_out, 6'd2);

        $display("[TB] invalid opcode");
        cmds[15:0] = mkCmd(3'b110, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(3'b001, cmds, 1'b1);
        waitGrant(idx);
        checkOutput("inv_wrap_grant", idx, 0);
        applyStimulus(3'b000, cmds, 1'b1);
        waitRsp();
        checkOutput("inv_rsp_out", rsp_out, 0);
        checkOutput("inv_rsp_err", rsp_err, 1);
        cmds[15:0] = mkCmd(3'b010, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(3'b001, cmds, 1'b1);
        waitGrant(idx);
        applyStimulus(3'b000, cmds, 1'b1);
        waitRsp();
        checkOutput("after_inv_out", rsp_out, 6'd3);
        checkOutput("after_inv_err", rsp_err, 0);

        $display("[TB] shift capture");
        cmds[15:0] = mkCmd(3'b100, 3'd0, 3'd0, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus(3'b001, cmds, 1'b0);
        waitGrant(idx);
        applyStimulus(3'b000, cmds, 1'b0);
        waitRsp();
        checkOutput("shift_rsp_out", rsp_out, 6'd7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("shift_hold_out", rsp_out, 6'd7);
        end
        applyStimulus(3'b000, cmds, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("shift_after_valid", rsp_valid, 0);
        checkOutput("shift_after_out", rsp_out, 6'd7);

        $display("[TB] reset during wait");
        cmds[15:0] = mkCmd(3'b011, 3'd2, 3'd3, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(3'b001, cmds, 1'b1);
        waitGrant(idx);
        @(posedge clk); #2;
        checkOutput("wait_busy", busy, 1);
        reset = 1'b0;
        #1;
        checkOutput("arst_rsp_valid", rsp_valid, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_alsu_bus", alsu_bus, 0);
        checkOutput("arst_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("arst_no_rsp", rsp_valid, 0);
        end
        applyStimulus(3'b011, cmds, 1'b1);
        waitGrant(idx);
        checkOutput("arst_first_grant", idx, 0);
        applyStimulus(3'b000, cmds, 1'b1);
        waitRsp();

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            for (int j = 0; j < N; j++) cmds[16*j +: 16] = randCmd();
            applyStimulus(N'($urandom), cmds, $urandom_range(0, 3) != 0);
        end
        applyStimulus('0, cmds, 1'b1);
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
